deser160_testgen: RTL and testbench



---
 rtl/deser160_pkg.sv | 14 +
 rtl/deser160_sync2.sv | 26 ++
 rtl/deser160_testgen.sv | 174 +++++++++++++++++
 tb/tb_deser160_testgen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser160_pkg.sv
// rtl/deser160_pkg.sv - shared constants for the deser160 test-stream generator
package deser160_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_PAT   = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;
  localparam logic [1:0] MODE_FRAME = 2'd3;

  localparam logic [11:0] HEADER_DEFAULT  = 12'h7FC;
  localparam logic [11:0] TRAILER_DEFAULT = 12'h7FE;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

endpackage

// File: rtl/deser160_sync2.sv
// rtl/deser160_sync2.sv - width-parameterized 2-FF synchronizer into the sclk180 domain
module deser160_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/deser160_testgen.sv
// rtl/deser160_testgen.sv - serial test-stream generator: repeating pattern, PRBS7 or triggered frames
module deser160_testgen
  import deser160_pkg::*;
#(
  parameter int          PAYLOAD_BITS = 96,
  parameter logic [11:0] HEADER       = HEADER_DEFAULT,
  parameter logic [11:0] TRAILER      = TRAILER_DEFAULT
) (
  input  logic       sclk180,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [7:0] pattern,
  input  logic       trig_tgl,
  output logic       sdata,
  output logic       busy,
  output logic [7:0] missed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_TRL  = 2'd3;

  localparam logic [9:0] PAY_LAST  = 10'(PAYLOAD_BITS - 1);
  localparam logic [9:0] EDGE_LAST = 10'd11;

  logic [1:0] mode_s;
  logic [7:0] pattern_s;
  logic       trig_s;

  deser160_sync2 #(.W(2)) u_sync_mode (
    .clk   (sclk180),
    .reset (reset),
    .d     (mode),
    .q     (mode_s)
  );

  deser160_sync2 #(.W(8)) u_sync_pattern (
    .clk   (sclk180),
    .reset (reset),
    .d     (pattern),
    .q     (pattern_s)
  );

  deser160_sync2 #(.W(1)) u_sync_trig (
    .clk   (sclk180),
    .reset (reset),
    .d     (trig_tgl),
    .q     (trig_s)
  );

  logic [1:0] state_q, state_d;
  logic [9:0] fcnt_q, fcnt_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] pat_q, pat_d;
  logic [6:0] prbs_q, prbs_d;
  logic       sdata_q, sdata_d;
  logic       busy_q, busy_d;
  logic [7:0] missed_q, missed_d;
  logic       trig_dly_q, trig_dly_d;

  logic [6:0] prbs_cur;
  logic [6:0] prbs_adv;
  logic       trig_pulse;
  logic       start;
  logic       stream_mode;

  always_comb begin
    prbs_cur    = (prbs_q == '0) ? PRBS7_SEED : prbs_q;
    prbs_adv    = {prbs_cur[5:0], prbs_cur[6] ^ prbs_cur[5]};
    trig_pulse  = trig_s ^ trig_dly_q;
    stream_mode = (mode_q == MODE_PAT) || (mode_q == MODE_PRBS);
    start       = trig_pulse && (mode_q == MODE_FRAME) && (state_q == ST_IDLE) && !busy_q;

    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pcnt_d     = '0;
    mode_d     = mode_q;
    pat_d      = pat_q;
    prbs_d     = prbs_cur;
    sdata_d    = 1'b0;
    busy_d     = (state_q != ST_IDLE);
    missed_d   = missed_q;
    trig_dly_d = trig_s;

    case (state_q)
      ST_HDR: begin
        sdata_d = HEADER[fcnt_q[3:0]];
        if (fcnt_q == '0) begin
          state_d = ST_PAY;
          fcnt_d  = PAY_LAST;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      ST_PAY: begin
        sdata_d = prbs_cur[6];
        prbs_d  = prbs_adv;
        if (fcnt_q == '0) begin
          state_d = ST_TRL;
          fcnt_d  = EDGE_LAST;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      ST_TRL: begin
        sdata_d = TRAILER[fcnt_q[3:0]];
        if (fcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        case (mode_q)
          MODE_PAT: begin
            sdata_d = pat_q[~pcnt_q];
            pcnt_d  = pcnt_q + 1'b1;
          end
          MODE_PRBS: begin
            sdata_d = prbs_cur[6];
            prbs_d  = prbs_adv;
            pcnt_d  = pcnt_q + 1'b1;
          end
          default: ;
        endcase
        // Streaming modes only hand over at a word boundary so no partial word is sent.
        if (start) begin
          state_d = ST_HDR;
          fcnt_d  = EDGE_LAST;
        end else if (!stream_mode || pcnt_q == 3'd7) begin
          mode_d = mode_s;
          pat_d  = pattern_s;
        end
      end
    endcase

    if (trig_pulse && (state_q != ST_IDLE || busy_q) && missed_q != 8'hFF) begin
      missed_d = missed_q + 1'b1;
    end
  end

  always_ff @(posedge sclk180 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      pcnt_q     <= '0;
      mode_q     <= MODE_IDLE;
      pat_q      <= '0;
      prbs_q     <= PRBS7_SEED;
      sdata_q    <= 1'b0;
      busy_q     <= 1'b0;
      missed_q   <= '0;
      trig_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      pcnt_q     <= pcnt_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      prbs_q     <= prbs_d;
      sdata_q    <= sdata_d;
      busy_q     <= busy_d;
      missed_q   <= missed_d;
      trig_dly_q <= trig_dly_d;
    end
  end

  assign sdata  = sdata_q;
  assign busy   = busy_q;
  assign missed = missed_q;

endmodule

// File: tb/tb_deser160_testgen.sv
// tb/tb_deser160_testgen.sv - directed self-checking bench for deser160_testgen
module tb_deser160_testgen;

  localparam int PB = 96;

  logic       sclk180 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic       trig_tgl = 1'b0;
  logic       sdata;
  logic       busy;
  logic [7:0] missed;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] m;
  logic       sd [0:159];
  logic       bz [0:159];

  deser160_testgen #(.PAYLOAD_BITS(PB)) dut (
    .sclk180  (sclk180),
    .reset    (reset),
    .mode     (mode),
    .pattern  (pattern),
    .trig_tgl (trig_tgl),
    .sdata    (sdata),
    .busy     (busy),
    .missed   (missed)
  );

  always #3 sclk180 = ~sclk180;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bit(output logic b);
    b = m[6];
    m = {m[5:0], m[6] ^ m[5]};
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [7:0] pat);
    reset    = 1'b1;
    mode     = md;
    pattern  = pat;
    trig_tgl = 1'b0;
    repeat (2) @(negedge sclk180);
    reset = 1'b0;
  endtask

  task automatic wait_first_one(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge sclk180);
      if (sdata) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic capture_frame(input int n, input int switch_at);
    trig_tgl = ~trig_tgl;
    for (int i = 0; i < n; i++) begin
      @(negedge sclk180);
      sd[i] = sdata;
      bz[i] = busy;
      if (i == switch_at) mode = 2'd1;
    end
  endtask

  task automatic check_frame();
    logic [11:0] h, t;
    logic [95:0] pg, pe;
    logic        b;
    int          nb;
    h  = '0;
    t  = '0;
    nb = 0;
    m  = 7'h7F;
    for (int i = 0; i < 12; i++) h = {h[10:0], sd[3 + i]};
    for (int i = 0; i < 12; i++) t = {t[10:0], sd[111 + i]};
    for (int i = 0; i < PB; i++) begin
      pg[i] = sd[15 + i];
      model_bit(b);
      pe[i] = b;
    end
    for (int i = 0; i < 125; i++) if (bz[i]) nb++;
    check("busy_before_latency", bz[2], 1'b0);
    check("busy_rise_n3", bz[3], 1'b1);
    check("header", h, 12'h7FC);
    check("payload", pg, pe);
    check("trailer", t, 12'h7FE);
    check("busy_len", nb, 120);
    check("idle_after", {sd[123], bz[123]}, 2'b00);
  endtask

  initial begin
    bit          ok;
    logic        b;
    logic [127:0] got, exp;
    logic [15:0] v;
    logic [7:0]  w;
    int          rises, errs;
    logic        prev;

    // Reset values
    repeat (2) @(negedge sclk180);
    check("rst_sdata", sdata, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_missed", missed, 8'd0);

    // PRBS7: sequence, balance and period
    do_reset(2'd2, 8'h00);
    wait_first_one(ok);
    check("prbs_start_seen", ok, 1'b1);
    got = '0;
    exp = '0;
    got[0] = sdata;
    for (int i = 1; i < 127; i++) begin
      @(negedge sclk180);
      got[i] = sdata;
    end
    m = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      model_bit(b);
      exp[i] = b;
    end
    check("prbs_seq", got, exp);
    check("prbs_first7", got[6:0], 7'h7F);
    check("prbs_ones", $countones(got[126:0]), 64);
    v = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge sclk180);
      v[i] = sdata;
    end
    check("prbs_period", v[13:0], got[13:0]);

    // Asynchronous reset mid-stream, then PRBS restarts from the seed
    @(posedge sclk180);
    #1 reset = 1'b1;
    #1;
    check("async_rst_sdata", sdata, 1'b0);
    check("async_rst_missed", missed, 8'd0);
    @(negedge sclk180);
    reset = 1'b0;
    wait_first_one(ok);
    check("prbs_restart_seen", ok, 1'b1);
    w[7] = sdata;
    for (int i = 6; i >= 0; i--) begin
      @(negedge sclk180);
      w[i] = sdata;
    end
    check("prbs_restart8", w, 8'b1111_1110);

    // Pattern mode, word change only at wrap
    do_reset(2'd1, 8'hA5);
    wait_first_one(ok);
    check("pat_start_seen", ok, 1'b1);
    v = {15'd0, sdata};
    for (int i = 1; i < 16; i++) begin
      @(negedge sclk180);
      v = {v[14:0], sdata};
    end
    check("pat_a5a5", v, 16'hA5A5);
    w = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sclk180);
      w = {w[6:0], sdata};
    end
    pattern = 8'h0F;
    for (int i = 0; i < 6; i++) begin
      @(negedge sclk180);
      w = {w[6:0], sdata};
    end
    check("pat_hold_old_word", w, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      @(negedge sclk180);
      v = {v[14:0], sdata};
    end
    check("pat_new_word", v, 16'h0F0F);

    // Single frame
    do_reset(2'd3, 8'h00);
    repeat (8) @(negedge sclk180);
    capture_frame(125, -1);
    check_frame();
    check("frame_missed0", missed, 8'd0);

    // Second trigger while busy
    rises = 0;
    prev  = busy;
    trig_tgl = ~trig_tgl;
    for (int i = 0; i < 250; i++) begin
      @(negedge sclk180);
      if (busy && !prev) rises++;
      prev = busy;
      if (i == 50) trig_tgl = ~trig_tgl;
    end
    check("single_frame", rises, 1);
    check("missed_one", missed, 8'd1);

    // Saturation of the missed counter
    for (int i = 0; i < 300; i++) begin
      trig_tgl = ~trig_tgl;
      @(negedge sclk180);
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sclk180);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("sat_busy_drops", ok, 1'b1);
    check("missed_saturated", missed, 8'd255);

    // Reset in the middle of a header
    do_reset(2'd3, 8'h00);
    repeat (8) @(negedge sclk180);
    capture_frame(6, -1);
    check("midframe_pre", {sd[5], bz[5]}, 2'b11);
    reset = 1'b1;
    #1;
    check("midframe_rst", {sdata, busy}, 2'b00);
    trig_tgl = 1'b0;
    repeat (2) @(negedge sclk180);
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sclk180);
      if (sdata || busy) errs++;
    end
    check("no_partial_trailer", errs, 0);

    // Mode change 3 -> 1 during payload
    do_reset(2'd3, 8'hA5);
    repeat (8) @(negedge sclk180);
    capture_frame(140, 60);
    check_frame();
    v = '0;
    for (int i = 124; i < 140; i++) v = {v[14:0], sd[i]};
    check("switch_to_pattern", v, 16'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
